vga_timing_gen: RTL

- Parametrised VGA timing generator and pixel-output stage. Successor to the fixed 640x480 controller.
- Generates h/v counters and sync pulses with configurable polarity, requests pixel coordinates ahead of time, and aligns RGB with syncs for a pixel source of configurable latency.
- Sits between the pixel source (framebuffer/renderer) and the board DAC pins.
- Adds frame/line strobes and a blanking-aware coordinate-valid flag.

---
 rtl/vga_timing_pkg.sv | 28 ++
 rtl/vga_delay_line.sv | 39 +++
 rtl/vga_timing_gen.sv | 137 +++++++++++++
 3 files changed

// File: rtl/vga_timing_pkg.sv
// Shared timing constants, frame-total helper and the per-pixel control word
// used by the VGA timing generator.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Sync bits are stored as "asserted" flags; polarity is applied at the pins.
    typedef struct packed {
        logic hs;
        logic vs;
        logic active;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '{hs: 1'b0, vs: 1'b0, active: 1'b0};

    function automatic int calc_total(input int active, input int fp,
                                      input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Shift register of parametrised depth and width with synchronous reset to a
// fixed value; depth 0 is a plain wire.
module vga_delay_line #(
    parameter int               DEPTH   = 2,
    parameter int               WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    generate
        if (DEPTH == 0) begin : g_bypass
            logic w_unused;
            assign w_unused = i_clk ^ i_rst;
            assign o_data   = i_data;
        end else begin : g_shift
            logic [WIDTH-1:0] r_stage [DEPTH];

            always_ff @(posedge i_clk) begin
                if (i_rst) begin
                    for (int i = 0; i < DEPTH; i++) begin
                        r_stage[i] <= RST_VAL;
                    end
                end else begin
                    r_stage[0] <= i_data;
                    for (int i = 1; i < DEPTH; i++) begin
                        r_stage[i] <= r_stage[i-1];
                    end
                end
            end

            assign o_data = r_stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA timing generator: issues pixel requests ahead of time and
// re-aligns syncs/blanking with RGB returned by a fixed-latency pixel source.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int LATENCY  = 2,
    parameter int COORD_W  = 10,
    parameter int COLOR_W  = 8
) (
    input  logic               CLOCK_25,
    input  logic               reset,
    input  logic [COLOR_W-1:0] R_in,
    input  logic [COLOR_W-1:0] G_in,
    input  logic [COLOR_W-1:0] B_in,
    output logic [COORD_W-1:0] next_x,
    output logic [COORD_W-1:0] next_y,
    output logic               next_valid,
    output logic               frame_start,
    output logic               line_start,
    output logic               VGA_CLK,
    output logic               VGA_HS,
    output logic               VGA_VS,
    output logic               VGA_BLANK_N,
    output logic               VGA_SYNC_N,
    output logic [COLOR_W-1:0] VGA_R,
    output logic [COLOR_W-1:0] VGA_G,
    output logic [COLOR_W-1:0] VGA_B
);

    localparam int H_TOTAL = calc_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = calc_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOTAL - 1);
    localparam logic [COORD_W-1:0] H_ACT_END  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_END  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] H_SYNC_BEG = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] H_SYNC_END = COORD_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [COORD_W-1:0] V_SYNC_BEG = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] V_SYNC_END = COORD_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [COORD_W-1:0] r_h_cnt;
    logic [COORD_W-1:0] r_v_cnt;

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            r_h_cnt <= '0;
            r_v_cnt <= '0;
        end else if (r_h_cnt == H_LAST) begin
            r_h_cnt <= '0;
            r_v_cnt <= (r_v_cnt == V_LAST) ? '0 : r_v_cnt + 1'b1;
        end else begin
            r_h_cnt <= r_h_cnt + 1'b1;
        end
    end

    // Request stage: combinational from the counters.
    logic  w_active;
    ctrl_t w_ctrl;

    always_comb begin
        w_active    = (r_h_cnt < H_ACT_END) && (r_v_cnt < V_ACT_END);
        next_valid  = w_active;
        next_x      = w_active ? r_h_cnt : '0;
        next_y      = w_active ? r_v_cnt : '0;
        line_start  = (r_h_cnt == '0);
        frame_start = (r_h_cnt == '0) && (r_v_cnt == '0);

        w_ctrl        = CTRL_IDLE;
        w_ctrl.hs     = (r_h_cnt >= H_SYNC_BEG) && (r_h_cnt < H_SYNC_END);
        w_ctrl.vs     = (r_v_cnt >= V_SYNC_BEG) && (r_v_cnt < V_SYNC_END);
        w_ctrl.active = w_active;
    end

    // Control word waits LATENCY cycles so it meets the matching pixel data.
    logic [$bits(ctrl_t)-1:0] w_dly_bits;
    ctrl_t                    w_dly;

    vga_delay_line #(
        .DEPTH  (LATENCY),
        .WIDTH  ($bits(ctrl_t)),
        .RST_VAL(CTRL_IDLE)
    ) u_ctrl_dly (
        .i_clk (CLOCK_25),
        .i_rst (reset),
        .i_data(w_ctrl),
        .o_data(w_dly_bits)
    );

    assign w_dly = ctrl_t'(w_dly_bits);

    // Output stage: syncs and RGB registered together, so they never skew.
    logic               r_hs;
    logic               r_vs;
    logic               r_blank_n;
    logic [COLOR_W-1:0] r_red;
    logic [COLOR_W-1:0] r_grn;
    logic [COLOR_W-1:0] r_blu;

    always_ff @(posedge CLOCK_25) begin
        if (reset) begin
            r_hs      <= ~HS_POL;
            r_vs      <= ~VS_POL;
            r_blank_n <= 1'b0;
            r_red     <= '0;
            r_grn     <= '0;
            r_blu     <= '0;
        end else begin
            r_hs      <= w_dly.hs ? HS_POL : ~HS_POL;
            r_vs      <= w_dly.vs ? VS_POL : ~VS_POL;
            r_blank_n <= w_dly.active;
            r_red     <= w_dly.active ? R_in : '0;
            r_grn     <= w_dly.active ? G_in : '0;
            r_blu     <= w_dly.active ? B_in : '0;
        end
    end

    assign VGA_CLK     = CLOCK_25;
    assign VGA_SYNC_N  = 1'b1;
    assign VGA_HS      = r_hs;
    assign VGA_VS      = r_vs;
    assign VGA_BLANK_N = r_blank_n;
    assign VGA_R       = r_red;
    assign VGA_G       = r_grn;
    assign VGA_B       = r_blu;

endmodule
